axis_narrow_shift_register: RTL and testbench

// - AXI4-Stream width down-converter: one wide axis_in beat -> N narrow axis_out beats, N = IN_BYTES/OUT_BYTES.
// - Shift-register based: the output is always the low subword of a holding register, shifted right on each

---
 rtl/axis_narrow_shift_register.sv | 128 ++++++++++++
 tb/tb_axis_narrow_shift_register.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_narrow_shift_register.sv
// rtl/axis_narrow_shift_register.sv - AXI-Stream width down-converter built on a right-shifting holding register.
// Optional SVA protocol checks compile in when AXIS_NARROW_SR_ASSERT_EN is defined.
module axis_narrow_shift_register #(
    parameter int IN_BYTES            = 8,
    parameter int OUT_BYTES           = 2,
    parameter int ID_W                = 4,
    parameter int DEST_W              = 4,
    parameter int USER_W              = 2,
    parameter bit DROP_EMPTY_SUBWORDS = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [IN_BYTES*8-1:0]  in_tdata,
    input  logic [IN_BYTES-1:0]    in_tkeep,
    input  logic                   in_tlast,
    input  logic [USER_W-1:0]      in_tuser,
    input  logic [ID_W-1:0]        in_tid,
    input  logic [DEST_W-1:0]      in_tdest,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    output logic [OUT_BYTES*8-1:0] out_tdata,
    output logic [OUT_BYTES-1:0]   out_tkeep,
    output logic [OUT_BYTES-1:0]   out_tstrb,
    output logic                   out_tlast,
    output logic [USER_W-1:0]      out_tuser,
    output logic [ID_W-1:0]        out_tid,
    output logic [DEST_W-1:0]      out_tdest,
    output logic                   out_tvalid,
    input  logic                   out_tready
);
    localparam int N     = IN_BYTES / OUT_BYTES;
    localparam int CW    = $clog2(N + 1);
    localparam int OUT_W = OUT_BYTES * 8;

    if (IN_BYTES <= OUT_BYTES) begin : g_err_ratio
        $error("axis_narrow_shift_register: IN_BYTES must exceed OUT_BYTES");
    end
    if ((IN_BYTES % OUT_BYTES) != 0) begin : g_err_div
        $error("axis_narrow_shift_register: OUT_BYTES must divide IN_BYTES");
    end

    logic [IN_BYTES*8-1:0] sr_data;
    logic [IN_BYTES-1:0]   sr_keep;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         load_len;
    logic                  hold_last;
    logic [USER_W-1:0]     hold_user;
    logic [ID_W-1:0]       hold_id;
    logic [DEST_W-1:0]     hold_dest;
    logic                  in_fire;
    logic                  out_fire;

    assign out_tvalid = (cnt != '0);
    assign out_tdata  = sr_data[OUT_W-1:0];
    assign out_tkeep  = sr_keep[OUT_BYTES-1:0];
    assign out_tstrb  = '1;
    assign out_tlast  = hold_last && (cnt == CW'(1));
    assign out_tuser  = hold_user;
    assign out_tid    = hold_id;
    assign out_tdest  = hold_dest;

    // Accepting while the last subword leaves keeps full rate with no bubble.
    assign in_tready = resetn && ((cnt == '0) || ((cnt == CW'(1)) && out_tready));
    assign in_fire   = in_tvalid && in_tready;
    assign out_fire  = out_tvalid && out_tready;

    always_comb begin
        load_len = '0;
        if (DROP_EMPTY_SUBWORDS) begin
            for (int i = 0; i < N; i++) begin
                if (|in_tkeep[i*OUT_BYTES +: OUT_BYTES]) begin
                    load_len = CW'(i + 1);
                end
            end
            // An empty final beat still emits one keep=0 subword to carry tlast.
            if (load_len == '0 && in_tlast) begin
                load_len = CW'(1);
            end
        end else begin
            load_len = CW'(N);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            sr_keep <= '0;
        end else if (in_fire) begin
            sr_data   <= in_tdata;
            sr_keep   <= in_tkeep;
            cnt       <= load_len;
            hold_last <= in_tlast;
            hold_user <= in_tuser;
            hold_id   <= in_tid;
            hold_dest <= in_tdest;
        end else if (out_fire) begin
            sr_data <= sr_data >> OUT_W;
            sr_keep <= sr_keep >> OUT_BYTES;
            cnt     <= cnt - CW'(1);
        end
    end

`ifdef AXIS_NARROW_SR_ASSERT_EN
    logic              mid_pkt;
    logic [ID_W-1:0]   pkt_id;
    logic [DEST_W-1:0] pkt_dest;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mid_pkt <= 1'b0;
        end else if (in_fire) begin
            mid_pkt  <= !in_tlast;
            pkt_id   <= in_tid;
            pkt_dest <= in_tdest;
        end
    end

    a_keep_contig: assert property (@(posedge clk) disable iff (!resetn)
        in_fire |-> ((in_tkeep & (in_tkeep + 1'b1)) == '0));
    a_out_stable: assert property (@(posedge clk) disable iff (!resetn)
        (out_tvalid && !out_tready) |=> (out_tvalid && $stable(out_tdata) && $stable(out_tkeep)
            && $stable(out_tlast) && $stable(out_tuser) && $stable(out_tid) && $stable(out_tdest)));
    a_ready_busy: assert property (@(posedge clk) disable iff (!resetn)
        (cnt > CW'(1)) |-> !in_tready);
    a_pkt_route: assert property (@(posedge clk) disable iff (!resetn)
        (in_fire && mid_pkt) |-> ((in_tid == pkt_id) && (in_tdest == pkt_dest)));
`endif
endmodule

// File: tb/tb_axis_narrow_shift_register.sv
// tb/tb_axis_narrow_shift_register.sv - scoreboard bench for the 8B->2B narrow shift-register converter.
module tb_axis_narrow_shift_register;
    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic [1:0]  s;
        logic        l;
        logic [1:0]  u;
        logic [3:0]  id;
        logic [3:0]  de;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] in_tdata = '0;
    logic [7:0]  in_tkeep = '0;
    logic        in_tlast = 1'b0;
    logic [1:0]  in_tuser = '0;
    logic [3:0]  in_tid = '0;
    logic [3:0]  in_tdest = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tvalid_z = 1'b0;
    logic        in_tready, in_tready_z;
    logic        out_tready = 1'b1;
    logic        out_tready_z = 1'b1;
    logic [15:0] out_tdata, out_tdata_z;
    logic [1:0]  out_tkeep, out_tkeep_z, out_tstrb, out_tstrb_z;
    logic        out_tlast, out_tlast_z, out_tvalid, out_tvalid_z;
    logic [1:0]  out_tuser, out_tuser_z;
    logic [3:0]  out_tid, out_tid_z, out_tdest, out_tdest_z;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    beats = 0, beats_z = 0;
    int    first_cyc = 0, last_cyc = 0;
    int    n;
    beat_t q[$];
    beat_t qz[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_narrow_shift_register #(.IN_BYTES(8), .OUT_BYTES(2), .ID_W(4), .DEST_W(4), .USER_W(2),
        .DROP_EMPTY_SUBWORDS(1'b1)) u_dut (
        .clk(clk), .resetn(resetn),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser(in_tuser),
        .in_tid(in_tid), .in_tdest(in_tdest), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tstrb(out_tstrb), .out_tlast(out_tlast),
        .out_tuser(out_tuser), .out_tid(out_tid), .out_tdest(out_tdest),
        .out_tvalid(out_tvalid), .out_tready(out_tready));

    axis_narrow_shift_register #(.IN_BYTES(8), .OUT_BYTES(2), .ID_W(4), .DEST_W(4), .USER_W(2),
        .DROP_EMPTY_SUBWORDS(1'b0)) u_dut_z (
        .clk(clk), .resetn(resetn),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser(in_tuser),
        .in_tid(in_tid), .in_tdest(in_tdest), .in_tvalid(in_tvalid_z), .in_tready(in_tready_z),
        .out_tdata(out_tdata_z), .out_tkeep(out_tkeep_z), .out_tstrb(out_tstrb_z), .out_tlast(out_tlast_z),
        .out_tuser(out_tuser_z), .out_tid(out_tid_z), .out_tdest(out_tdest_z),
        .out_tvalid(out_tvalid_z), .out_tready(out_tready_z));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected narrow beats for one wide beat.
    task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [1:0] u, input logic [3:0] id, input logic [3:0] de,
                             input bit drop, input bit to_z);
        int    len;
        beat_t b;
        len = 4;
        if (drop) begin
            len = 0;
            for (int i = 0; i < 4; i++) if (k[2*i +: 2] != 2'b00) len = i + 1;
            if (len == 0 && l) len = 1;
        end
        for (int i = 0; i < len; i++) begin
            b = '{d: d[16*i +: 16], k: k[2*i +: 2], s: 2'b11, l: l && (i == len - 1), u: u, id: id, de: de};
            if (to_z) qz.push_back(b); else q.push_back(b);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [1:0] u, input logic [3:0] id, input logic [3:0] de,
                        input bit to_z, output int waited);
        bit ok;
        in_tdata = d; in_tkeep = k; in_tlast = l; in_tuser = u; in_tid = id; in_tdest = de;
        push_word(d, k, l, u, id, de, !to_z, to_z);
        if (to_z) in_tvalid_z = 1'b1; else in_tvalid = 1'b1;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (to_z ? in_tready_z : in_tready) ok = 1'b1;
            else waited++;
        end
        chk("send_handshake", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tvalid_z = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || qz.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 64'(q.size() + qz.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t obs;
        if (resetn && out_tvalid) begin
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL extra_beat observed=%0h expected=none", out_tdata);
            end
            if (q.size() != 0) begin
                obs = '{d: out_tdata, k: out_tkeep, s: out_tstrb, l: out_tlast, u: out_tuser,
                        id: out_tid, de: out_tdest};
                chk("out_beat", 64'(obs), 64'(q[0]));
                if (out_tready) begin
                    void'(q.pop_front());
                    if (beats == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats++;
                end
            end
        end
    end

    always @(negedge clk) begin
        beat_t obs;
        if (resetn && out_tvalid_z) begin
            total++;
            assert (qz.size() != 0) else begin
                bad++;
                $error("FAIL extra_beat_z observed=%0h expected=none", out_tdata_z);
            end
            if (qz.size() != 0) begin
                obs = '{d: out_tdata_z, k: out_tkeep_z, s: out_tstrb_z, l: out_tlast_z, u: out_tuser_z,
                        id: out_tid_z, de: out_tdest_z};
                chk("out_beat_z", 64'(obs), 64'(qz[0]));
                if (out_tready_z) begin
                    void'(qz.pop_front());
                    beats_z++;
                end
            end
        end
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_in_tready", 64'(in_tready), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_out_tkeep", 64'(out_tkeep), 64'd0);
        chk("rst_in_tready_rel", 64'(in_tready), 64'd1);
        @(posedge clk);
        #1;

        // T1 single word; tready low for 3 cycles after load
        send(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 2'd2, 4'd3, 4'd5, 1'b0, n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) chk("t1_latency", 64'(out_tvalid), 64'd1);
            chk("t1_ready_low", 64'(in_tready), 64'd0);
        end
        @(negedge clk);
        chk("t1_ready_back", 64'(in_tready), 64'd1);
        drain();
        chk("t1_beats", 64'(beats), 64'd4);

        // T2 back-to-back words at full rate
        beats = 0;
        send(64'h8888_7777_6666_5555, 8'hFF, 1'b0, 2'd1, 4'd7, 4'd2, 1'b0, n);
        send(64'hCCCC_BBBB_AAAA_9999, 8'hFF, 1'b0, 2'd1, 4'd7, 4'd2, 1'b0, n);
        chk("t2_gap1", 64'(n), 64'd3);
        send(64'h0F0F_E0E0_D0D0_C0C0, 8'hFF, 1'b1, 2'd1, 4'd7, 4'd2, 1'b0, n);
        chk("t2_gap2", 64'(n), 64'd3);
        drain();
        chk("t2_beats", 64'(beats), 64'd12);
        chk("t2_no_idle", 64'(last_cyc - first_cyc), 64'd11);

        // T3 partial keep, with and without empty-subword suppression
        beats = 0;
        send(64'hDDDD_CCCC_BBBB_AAAA, 8'h0F, 1'b1, 2'd0, 4'd1, 4'd1, 1'b0, n);
        drain();
        chk("t3_drop_beats", 64'(beats), 64'd2);
        beats_z = 0;
        send(64'hDDDD_CCCC_BBBB_AAAA, 8'h0F, 1'b1, 2'd0, 4'd1, 4'd1, 1'b1, n);
        drain();
        chk("t3_nodrop_beats", 64'(beats_z), 64'd4);

        // T4 output backpressure 1,0,1,0...
        beats = 0;
        fork
            send(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 2'd3, 4'd9, 4'd6, 1'b0, n);
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk);
                    #1;
                    out_tready = ~out_tready;
                end
            end
        join
        out_tready = 1'b1;
        drain();
        chk("t4_beats", 64'(beats), 64'd4);

        // T5 reset after two subwords
        beats = 0;
        send(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1, 2'd1, 4'd2, 4'd3, 1'b0, n);
        n = 0;
        while (beats < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_two_sent", 64'(beats), 64'd2);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t5_rst_ready", 64'(in_tready), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", 64'(out_tvalid), 64'd0);
        @(posedge clk);
        #1;
        beats = 0;
        send(64'h0004_0003_0002_0001, 8'hFF, 1'b1, 2'd0, 4'd4, 4'd4, 1'b0, n);
        drain();
        chk("t5_new_beats", 64'(beats), 64'd4);

        // T6 empty keep
        beats = 0;
        send(64'hFFFF_FFFF_FFFF_5A5A, 8'h00, 1'b0, 2'd0, 4'd8, 4'd8, 1'b0, n);
        repeat (3) @(negedge clk);
        chk("t6_consumed_valid", 64'(out_tvalid), 64'd0);
        chk("t6_consumed_beats", 64'(beats), 64'd0);
        @(posedge clk);
        #1;
        send(64'hFFFF_FFFF_FFFF_5A5A, 8'h00, 1'b1, 2'd0, 4'd8, 4'd8, 1'b0, n);
        drain();
        chk("t6_last_beats", 64'(beats), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
